rr_arbiter_n_hold: RTL and testbench
====================================

# rr_arbiter_n_hold

Parametrised N-requester round-robin arbiter with registered one-hot grants and grant locking. A requester that wins keeps the grant for as long as it holds its request asserted. An optional hold limit forces rotation when other requesters are waiting. The block sits in front of shared resources (bus ports, memory banks, FIFO write ports) where a grant must persist across multi-cycle transfers.

## Interface
- N, default 4: number of requesters; legal range N >= 2.
- MAX_HOLD, default 8: maximum consecutive grant cycles under contention; legal range MAX_HOLD >= 1; used only with RR_ARB_MAX_HOLD_EN.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- requests  input  N  request vector; bit i high means requester i wants the resource; sampled on clk.
- grants  output  N  registered grant; one-hot or all-zero.
- grant_valid  output  1  registered; high when any grant bit is set.
- grant_idx  output  $clog2(N)  registered binary index of the granted requester; 0 when grant_valid is low.

## Operation
- State:
  - owner (index plus valid flag, which drives the outputs).
  - ptr: priority pointer, width $clog2(N).
  - hold_cnt: width $clog2(MAX_HOLD+1), saturating.
- Arbitration: search requests circularly starting at ptr (ptr, ptr+1, … wrapping N-1 to 0). The first set bit wins.
- Each rising edge, in priority order:
  - rst: owner invalid, grants=0, grant_valid=0, grant_idx=0, ptr=0, hold_cnt=0.
  - Owner valid and requests[owner] high, and not preempted: keep grant; hold_cnt increments, saturating at MAX_HOLD.
  - Owner valid and requests[owner] low: release. Arbitrate the same cycle from ptr with no idle gap; a grant goes to the winner, or all-zero if no requests.
  - Owner invalid: arbitrate from ptr.
  - Preempted (macro only): hold_cnt == MAX_HOLD and any other request bit is high. Arbitrate from owner+1 with the owner's bit masked, so the grant must move.
- On every new grant to winner w:
  - ptr = (w+1) mod N, wrapping N-1 to 0.
  - hold_cnt = 1.
- Re-granting the same requester after a release counts as a new grant; hold_cnt is reset.
- Requests are synchronous to clk. Grant bits never depend combinationally on the current requests.

## Timing
- Latency: a request sampled at edge k produces a grant visible after edge k; this is one cycle of latency.
- Release: the owner drops its request during cycle k. After edge k, grants shows the next winner or zero, so one trailing grant cycle is seen with the request low.
- Handover occurs back-to-back with no dead cycle.
- Reset mid-transfer: the grant drops to zero on the reset edge. After reset, priority restarts at requester 0.
- Simultaneous release and new requests resolve in one arbitration on a single edge.
- A requester whose bit is low at the arbitration edge is skipped; there is no memory of past requests.

## Configuration
- RR_ARB_MAX_HOLD_EN defined:
  - The hold-limit preemption above is compiled in.
  - Under contention, an owner holds for at most MAX_HOLD consecutive cycles.
  - With no other request pending, the owner keeps the grant indefinitely and hold_cnt stays at MAX_HOLD.
- RR_ARB_MAX_HOLD_EN undefined:
  - hold_cnt and the preemption logic are absent.
  - The owner keeps the grant for as long as its request stays high; this is pure lock mode.
  - Rotation happens only on release.

## Test plan
All scenarios use N=4 and MAX_HOLD=3.
- Reset, then requests=0001 from cycle 1: grants=0000 in cycle 1, then 0001 with grant_idx=0 and grant_valid=1 from cycle 2. Drop the request: grants=0000 on the following cycle.
- Macro on, requests=1111 held steady: grants repeats 0001×3, 0010×3, 0100×3, 1000×3, then 0001. This shows ptr wrap from 3 to 0.
- Macro off, requests=1111 held steady: grants=0001 forever. Then clear bit 0 (requests=1110): next cycle grants=0010 with no zero gap.
- Handover fairness: requester 2 owns the grant; then requests=1011 with bit 2 low. Next grants=1000 (search starts at ptr=3). After requester 3 releases, grants=0001.
- Macro on, solo requester: requests=0100 for 10 cycles gives grants=0100 throughout. Assert bit 0 once hold_cnt is saturated: the next edge gives grants=0001.
- Reset mid-operation: grants=0010 with requests=1111; assert rst for 1 cycle. Grants=0000 in the reset cycle, then 0001 next, confirming ptr=0.

Source files
------------

// File: rtl/rr_arbiter_n_hold_if.sv
// Request/grant bundle for rr_arbiter_n_hold. The requester side uses master
// and the arbiter uses slave. N here must match the arbiter's N.
interface rr_arbiter_n_hold_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  requests;
  logic [N-1:0]  grants;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  modport master (output requests, input grants, grant_valid, grant_idx);
  modport slave  (input requests, output grants, grant_valid, grant_idx);
endinterface

// File: rtl/rr_arbiter_n_hold.sv
// N-way round-robin arbiter with registered one-hot grants and grant locking.
// Define RR_ARB_MAX_HOLD_EN to force rotation after MAX_HOLD cycles under contention.
module rr_arbiter_n_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_arbiter_n_hold_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter_n_hold: needs N >= 2 and MAX_HOLD >= 1");
  end

  logic [N-1:0]  grants_q, grants_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  req;
  logic          keep;
  logic          preempt;
  logic [N-1:0]  pick_req;
  logic [IW-1:0] pick_start;
  logic [IW:0]   pick;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + IW'(1);
  endfunction

  // Returns {found, index}: first set bit at or after start, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r,
                                          input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] win;
    int            j;
    found = 1'b0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (r[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
    return {found, win};
  endfunction

`ifdef RR_ARB_MAX_HOLD_EN
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]  others;
`endif

  always_comb begin
    req           = bus.requests;
    grants_d      = grants_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    keep          = grant_valid_q && req[grant_idx_q];
    pick_req      = req;
    pick_start    = ptr_q;
`ifdef RR_ARB_MAX_HOLD_EN
    hold_cnt_d    = hold_cnt_q;
    others        = req & ~grants_q;
    preempt       = keep && (hold_cnt_q == HW'(MAX_HOLD)) && (|others);
    // Masking the owner guarantees the grant moves on preemption.
    if (preempt) begin
      pick_req   = others;
      pick_start = nxt(grant_idx_q);
    end
`else
    preempt       = 1'b0;
`endif
    pick = rr_pick(pick_req, pick_start);

    if (keep && !preempt) begin
`ifdef RR_ARB_MAX_HOLD_EN
      if (hold_cnt_q != HW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + HW'(1);
`endif
    end else if (pick[IW]) begin
      grants_d      = N'(1) << pick[IW-1:0];
      grant_valid_d = 1'b1;
      grant_idx_d   = pick[IW-1:0];
      ptr_d         = nxt(pick[IW-1:0]);
`ifdef RR_ARB_MAX_HOLD_EN
      hold_cnt_d    = HW'(1);
`endif
    end else begin
      grants_d      = '0;
      grant_valid_d = 1'b0;
      grant_idx_d   = '0;
`ifdef RR_ARB_MAX_HOLD_EN
      hold_cnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      ptr_q         <= '0;
`ifdef RR_ARB_MAX_HOLD_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      grants_q      <= grants_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      ptr_q         <= ptr_d;
`ifdef RR_ARB_MAX_HOLD_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign bus.grants      = grants_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
endmodule

// File: tb/tb_rr_arbiter_n_hold.sv
// Directed and randomized bench for rr_arbiter_n_hold (N=4, MAX_HOLD=3),
// checked against an owner/pointer reference model.
module tb_rr_arbiter_n_hold;
  localparam int NR   = 4;
  localparam int MAXH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_arbiter_n_hold_if #(.N(NR)) bus ();

  rr_arbiter_n_hold #(.N(NR), .MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: owner keeps while requesting; otherwise scan forward from the pointer.
  task automatic model_step(input logic [3:0] r, input bit rr);
    int          start;
    int          w;
    logic [3:0]  cand;
    if (rr) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
      return;
    end
    start = m_ptr;
    cand  = r;
    if (m_owner >= 0 && r[m_owner]) begin
`ifdef RR_ARB_MAX_HOLD_EN
      cand = r & ~(4'(1) << m_owner);
      if (!(m_hold == MAXH && cand != 4'b0)) begin
        if (m_hold < MAXH) m_hold++;
        return;
      end
      start = (m_owner + 1) % NR;
`else
      return;
`endif
    end
    w = -1;
    for (int k = 0; k < NR && w < 0; k++)
      if (cand[(start + k) % NR]) w = (start + k) % NR;
    if (w >= 0) begin
      m_owner = w; m_ptr = (w + 1) % NR; m_hold = 1;
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic cycle(input logic [3:0] r, input bit rr,
                       input logic [3:0] exp_g, input bit use_exp);
    logic [3:0] eg;
    @(negedge clk);
    bus.requests = r;
    rst          = rr;
    @(posedge clk);
    model_step(r, rr);
    #1;
    eg = (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0;
    chk("grants", 32'(bus.grants), 32'(eg));
    chk("grant_valid", 32'(bus.grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("grant_idx", 32'(bus.grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    if (use_exp) chk("directed_grants", 32'(bus.grants), 32'(exp_g));
  endtask

  initial begin
    logic [3:0] r;
    bit         rr;
    bus.requests = '0;

    // Reset, single requester, then release.
    cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1);

    // All requesting: rotation every MAX_HOLD cycles, or pure lock.
    cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 13; i++) begin
`ifdef RR_ARB_MAX_HOLD_EN
      cycle(4'b1111, 1'b0, 4'(1) << ((i / MAXH) % NR), 1'b1);
`else
      cycle(4'b1111, 1'b0, 4'b0001, 1'b1);
`endif
    end
    cycle(4'b1110, 1'b0, 4'b0010, 1'b1);

    // Handover starts search at the pointer past the last winner.
    cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
    cycle(4'b0100, 1'b0, 4'b0100, 1'b1);
    cycle(4'b1011, 1'b0, 4'b1000, 1'b1);
    cycle(4'b0011, 1'b0, 4'b0001, 1'b1);

    // Solo owner saturates, then a competitor arrives.
    cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) cycle(4'b0100, 1'b0, 4'b0100, 1'b1);
`ifdef RR_ARB_MAX_HOLD_EN
    cycle(4'b0101, 1'b0, 4'b0001, 1'b1);
`else
    cycle(4'b0101, 1'b0, 4'b0100, 1'b1);
`endif

    // Reset mid-transfer restarts priority at requester 0.
    cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
    cycle(4'b0010, 1'b0, 4'b0010, 1'b1);
    cycle(4'b1111, 1'b1, 4'b0000, 1'b1);
    cycle(4'b1111, 1'b0, 4'b0001, 1'b1);

    // Random traffic; requests change on ~1/4 of cycles so holds occur.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      rr = ($urandom_range(60) == 0);
      cycle(r, rr, 4'b0000, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
